// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: o_result = a^d mod n.
// Right-to-left binary exponentiation. The base is kept in Montgomery form (t = a*R mod n)
// and the accumulator m is kept in plain form, so MontMul(m, t) keeps m plain and no exit
// conversion is needed. MUL and SQR share one radix-2 Montgomery multiplier.
// Optional build macro: MOD_EXP_EARLY_EXIT_EN stops the exponent scan after the highest
// set bit of d instead of always scanning all EXP_WIDTH bits.
module mod_exp_engine #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned EXP_WIDTH = WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [EXP_WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0]     i_n,
  output logic                 o_busy,
  output logic [WIDTH-1:0]     o_result,
  output logic                 o_finished,
  output logic                 o_error
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned KW = $clog2(EXP_WIDTH + 1);

  localparam logic [CW-1:0] CntLast  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CntFinal = CW'(WIDTH);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCheck = 3'd1;
  localparam logic [2:0] StPrep  = 3'd2;
  localparam logic [2:0] StScan  = 3'd3;
  localparam logic [2:0] StMul   = 3'd4;
  localparam logic [2:0] StSqr   = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     t_q, t_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [EXP_WIDTH-1:0] d_q, d_d;       // shifts right once per SQR; d_q[0] is d[k]
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH+1:0]     r_q, r_d;       // Montgomery partial result, always < 2n
  logic [WIDTH-1:0]     xs_q, xs_d;     // multiplier x operand, consumed LSB first
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 error_q, error_d;
  logic                 finished_q, finished_d;
  logic [KW-1:0]        k_end;

  logic [WIDTH:0]       dbl;
  logic [WIDTH-1:0]     prep_t;
  logic [WIDTH+1:0]     sum1, sum2, r_next;
  logic [WIDTH-1:0]     mm_final;
  logic                 n_bad;

`ifdef MOD_EXP_EARLY_EXIT_EN
  logic [KW-1:0] k_end_q, k_end_calc;

  // Scan length = index of highest set bit of d, plus one (0 when d = 0)
  always_comb begin
    k_end_calc = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (d_q[i]) k_end_calc = KW'(i + 1);
    end
  end

  // Latch the scan length while d is still unshifted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      k_end_q <= '0;
    end else if (state_q == StCheck) begin
      k_end_q <= k_end_calc;
    end
  end

  assign k_end = k_end_q;
`else
  assign k_end = KW'(EXP_WIDTH);
`endif

  // Shared datapath: modular doubling for PREP and one Montgomery step for MUL/SQR
  always_comb begin
    n_bad    = !n_q[0] || (n_q < WIDTH'(3));
    dbl      = {t_q, 1'b0};
    prep_t   = WIDTH'((dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl);
    // y is t for both MUL and SQR; sums stay below 4n, so WIDTH+2 bits suffice
    sum1     = r_q + {2'b00, (xs_q[0] ? t_q : {WIDTH{1'b0}})};
    sum2     = sum1 + (sum1[0] ? {2'b00, n_q} : {(WIDTH + 2){1'b0}});
    r_next   = sum2 >> 1;
    mm_final = WIDTH'((r_q >= {2'b00, n_q}) ? r_q - {2'b00, n_q} : r_q);
  end

  // Next-state and register-update logic
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    t_d        = t_q;
    m_d        = m_q;
    d_d        = d_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    xs_d       = xs_q;
    err_d      = err_q;
    result_d   = result_q;
    error_d    = error_q;
    finished_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          t_d     = i_a;
          d_d     = i_d;
          n_d     = i_n;
          state_d = StCheck;
        end
      end
      StCheck: begin
        m_d   = WIDTH'(1);
        k_d   = '0;
        cnt_d = '0;
        err_d = n_bad;
        // A rejected modulus passes through SCAN, which ends the run immediately
        state_d = n_bad ? StScan : StPrep;
      end
      StPrep: begin
        t_d = prep_t;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StScan;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScan: begin
        if (err_q || (k_q == k_end)) begin
          result_d   = err_q ? '0 : m_q;
          error_d    = err_q;
          finished_d = 1'b1;
          state_d    = StDone;
        end else begin
          r_d   = '0;
          cnt_d = '0;
          if (d_q[0]) begin
            xs_d    = m_q;
            state_d = StMul;
          end else begin
            xs_d    = t_q;
            state_d = StSqr;
          end
        end
      end
      StMul, StSqr: begin
        if (cnt_q != CntFinal) begin
          r_d   = r_next;
          xs_d  = xs_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end else begin
          r_d   = '0;
          cnt_d = '0;
          if (state_q == StMul) begin
            m_d     = mm_final;
            xs_d    = t_q;
            state_d = StSqr;
          end else begin
            t_d     = mm_final;
            k_d     = k_q + 1'b1;
            d_d     = d_q >> 1;
            state_d = StScan;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers, asynchronously cleared
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      t_q        <= '0;
      m_q        <= '0;
      d_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      r_q        <= '0;
      xs_q       <= '0;
      err_q      <= 1'b0;
      result_q   <= '0;
      error_q    <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      t_q        <= t_d;
      m_q        <= m_d;
      d_q        <= d_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      xs_q       <= xs_d;
      err_q      <= err_d;
      result_q   <= result_d;
      error_q    <= error_d;
      finished_q <= finished_d;
    end
  end

  assign o_busy     = (state_q != StIdle);
  assign o_result   = result_q;
  assign o_finished = finished_q;
  assign o_error    = error_q;

endmodule
